// File: rtl/i2c_canvas_reader_if.sv
// Host handshake plus open-drain I2C pin controls of the canvas reader.
// The reader itself uses the slave modport; the host/bus environment uses master.
interface i2c_canvas_reader_if;
  logic       start;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       nack_err;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [7:0] status_out;

  modport master (
    output start,
    output sda_in,
    input  scl_oe,
    input  sda_oe,
    input  busy,
    input  done,
    input  nack_err,
    input  x_out,
    input  y_out,
    input  status_out
  );

  modport slave (
    input  start,
    input  sda_in,
    output scl_oe,
    output sda_oe,
    output busy,
    output done,
    output nack_err,
    output x_out,
    output y_out,
    output status_out
  );
endinterface

// File: rtl/i2c_canvas_reader.sv
// I2C master polling the canvas slave: addresses it for read, fetches x, y and
// status bytes, and publishes them coherently with a one-cycle done strobe.
module i2c_canvas_reader #(
  parameter logic [6:0]  I2C_ADDR = 7'b1100100,
  parameter int unsigned CLK_DIV  = 4
) (
  input logic                clk,
  input logic                rst_n,
  i2c_canvas_reader_if.slave bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_ADDR     = 3'd2;
  localparam logic [2:0] ST_ADDR_ACK = 3'd3;
  localparam logic [2:0] ST_READ     = 3'd4;
  localparam logic [2:0] ST_MACK     = 3'd5;
  localparam logic [2:0] ST_STOP     = 3'd6;

  localparam logic [7:0] QMAX      = 8'(CLK_DIV - 1);
  localparam logic [7:0] ADDR_WORD = {I2C_ADDR, 1'b1};

  logic [2:0] state,    nxt_state;
  logic [1:0] phase,    nxt_phase;
  logic [7:0] qcnt,     nxt_qcnt;
  logic [2:0] bit_cnt,  nxt_bit;
  logic [1:0] byte_idx, nxt_byte;

  logic [7:0] shreg;
  logic [7:0] rx_x;
  logic [7:0] rx_y;
  logic [7:0] rx_s;

  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       nack_err;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [7:0] status_out;

  logic       scl_d;
  logic       sda_d;
  logic       q_last;
  logic       in_slot;
  logic       sample;
  logic       slot_end;
  logic       accept;
  logic       finish;
  logic       ack_bit;

  assign q_last   = (qcnt == QMAX);
  assign in_slot  = state inside {ST_ADDR, ST_ADDR_ACK, ST_READ, ST_MACK};
  assign sample   = in_slot && (phase == 2'd2) && q_last;
  assign slot_end = in_slot && (phase == 2'd3) && q_last;
  assign accept   = (state == ST_IDLE) && bus.start;
  assign finish   = (state == ST_STOP) && (phase == 2'd2) && q_last;
  assign ack_bit  = shreg[0];

  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    nxt_qcnt  = qcnt;
    nxt_bit   = bit_cnt;
    nxt_byte  = byte_idx;
    if (state == ST_IDLE) begin
      nxt_qcnt  = '0;
      nxt_phase = '0;
      if (bus.start) nxt_state = ST_START;
    end else begin
      nxt_qcnt = q_last ? '0 : qcnt + 8'd1;
      if (q_last) begin
        nxt_phase = phase + 2'd1;
        case (state)
          ST_START: begin
            if (phase == 2'd1) begin
              nxt_state = ST_ADDR;
              nxt_phase = '0;
              nxt_bit   = '0;
            end
          end
          ST_ADDR: begin
            if (slot_end) begin
              if (bit_cnt == 3'd7) nxt_state = ST_ADDR_ACK;
              else                 nxt_bit   = bit_cnt + 3'd1;
            end
          end
          ST_ADDR_ACK: begin
            if (slot_end) begin
              if (ack_bit) begin
                nxt_state = ST_STOP;
              end else begin
                nxt_state = ST_READ;
                nxt_bit   = '0;
                nxt_byte  = '0;
              end
            end
          end
          ST_READ: begin
            if (slot_end) begin
              if (bit_cnt == 3'd7) nxt_state = ST_MACK;
              else                 nxt_bit   = bit_cnt + 3'd1;
            end
          end
          ST_MACK: begin
            if (slot_end) begin
              if (byte_idx == 2'd2) begin
                nxt_state = ST_STOP;
              end else begin
                nxt_state = ST_READ;
                nxt_bit   = '0;
                nxt_byte  = byte_idx + 2'd1;
              end
            end
          end
          ST_STOP: begin
            if (phase == 2'd2) begin
              nxt_state = ST_IDLE;
              nxt_phase = '0;
            end
          end
          default: nxt_state = ST_IDLE;
        endcase
      end
    end
  end

  // Pin levels are decoded from the next state so the open-drain controls
  // come straight from flops and change exactly on quarter boundaries.
  always_comb begin
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (nxt_state)
      ST_START: sda_d = (nxt_phase == 2'd1);
      ST_ADDR: begin
        scl_d = ~nxt_phase[1];
        sda_d = ~ADDR_WORD[3'd7 - nxt_bit];
      end
      ST_ADDR_ACK, ST_READ: scl_d = ~nxt_phase[1];
      ST_MACK: begin
        scl_d = ~nxt_phase[1];
        sda_d = (nxt_byte != 2'd2);
      end
      ST_STOP: begin
        scl_d = (nxt_phase == 2'd0);
        sda_d = (nxt_phase != 2'd2);
      end
      default: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      qcnt       <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      rx_x       <= '0;
      rx_y       <= '0;
      rx_s       <= '0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nack_err   <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      status_out <= '0;
    end else begin
      state    <= nxt_state;
      phase    <= nxt_phase;
      qcnt     <= nxt_qcnt;
      bit_cnt  <= nxt_bit;
      byte_idx <= nxt_byte;
      scl_oe   <= scl_d;
      sda_oe   <= sda_d;
      done     <= finish;

      if (accept) begin
        busy     <= 1'b1;
        nack_err <= 1'b0;
      end

      if (sample && (state == ST_READ || state == ST_ADDR_ACK))
        shreg <= {shreg[6:0], bus.sda_in};

      if (slot_end && state == ST_ADDR_ACK && ack_bit)
        nack_err <= 1'b1;

      // Bytes are staged here and published together only at completion.
      if (slot_end && state == ST_READ && bit_cnt == 3'd7) begin
        case (byte_idx)
          2'd0:    rx_x <= shreg;
          2'd1:    rx_y <= shreg;
          default: rx_s <= shreg;
        endcase
      end

      if (finish) begin
        busy <= 1'b0;
        if (!nack_err) begin
          x_out      <= rx_x;
          y_out      <= rx_y;
          status_out <= rx_s;
        end
      end
    end
  end

  assign bus.scl_oe     = scl_oe;
  assign bus.sda_oe     = sda_oe;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.nack_err   = nack_err;
  assign bus.x_out      = x_out;
  assign bus.y_out      = y_out;
  assign bus.status_out = status_out;

endmodule
